// File: rtl/mriscv_pkg.sv
// Shared load/store func3 encodings and the LSU FSM state type.
package mriscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables / replicated write data, and
// load lane extraction with sign or zero extension.
module mem_align
  import mriscv_pkg::*;
(
  input  logic [2:0]  st_func3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (st_func3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << st_addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Halfword lane uses addr[1] only; addr[0] is dropped when not trapping.
  always_comb begin
    ld_byte = rdata[7:0];
    case (ld_addr_lo)
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
      default: ;
    endcase
    ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (ld_func3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_data = {24'd0, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_data = {16'd0, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Load/store unit: IDLE/REQ/RESP FSM, ack timeout and registered bus/writeback
// outputs. Optional misaligned-access trap under LSU_MISALIGN_TRAP_EN.
module mem_access
  import mriscv_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [4:0]  dest_o,
  output logic        bus_error,
  output logic        misaligned
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  mem_state_e    state;
  logic [CW-1:0] tmo_cnt;
  logic [2:0]    op_func3;
  logic [1:0]    op_addr_lo;
  logic          op_load;
  logic [4:0]    op_dest;
  logic          accept, illegal, misal_fault;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata, al_load;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid & in_ready & (is_load | is_store);

  always_comb begin
    if (is_store) illegal = !(func3 inside {F3_B, F3_H, F3_W});
    else          illegal = !(func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal_fault = ((func3[1:0] == 2'b01) && addr[0]) ||
                       ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misal_fault = 1'b0;
`endif

  mem_align u_align (
    .st_func3   (func3),
    .st_addr_lo (addr[1:0]),
    .store_data (store_data),
    .be         (al_be),
    .wdata      (al_wdata),
    .ld_func3   (op_func3),
    .ld_addr_lo (op_addr_lo),
    .rdata      (dmem_rdata),
    .load_data  (al_load)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      op_func3   <= '0;
      op_addr_lo <= '0;
      op_load    <= 1'b0;
      op_dest    <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
      dest_o     <= '0;
      bus_error  <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_func3   <= func3;
          op_addr_lo <= addr[1:0];
          op_load    <= is_load;
          op_dest    <= dest_i;
          tmo_cnt    <= '0;
          if (illegal || misal_fault) begin
            state      <= S_RESP;
            out_valid  <= 1'b1;
            bus_error  <= illegal;
            misaligned <= !illegal && misal_fault;
            result     <= '0;
            dest_o     <= '0;
          end else begin
            state      <= S_REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_be    <= al_be;
            dmem_wdata <= is_store ? al_wdata : '0;
          end
        end
        S_REQ: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (dmem_ack) begin
            state      <= S_RESP;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            out_valid  <= 1'b1;
            bus_error  <= 1'b0;
            misaligned <= 1'b0;
            result     <= op_load ? al_load : '0;
            dest_o     <= op_load ? op_dest : '0;
          end else if (tmo_cnt == CW'(ACK_TIMEOUT - 1)) begin
            state      <= S_RESP;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            out_valid  <= 1'b1;
            bus_error  <= 1'b1;
            misaligned <= 1'b0;
            result     <= '0;
            dest_o     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          out_valid  <= 1'b0;
          bus_error  <= 1'b0;
          misaligned <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed and random loads/stores, with a
// byte-arithmetic reference model; follows LSU_MISALIGN_TRAP_EN if defined.
module tb_mem_access;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] addr = '0, store_data = '0;
  logic [4:0]  dest_i = '0;
  logic        in_ready, dmem_req, dmem_we, out_valid, bus_error, misaligned;
  logic [31:0] dmem_addr, dmem_wdata, result;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [4:0]  dest_o;

  mem_access #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .func3(func3), .addr(addr),
    .store_data(store_data), .dest_i(dest_i), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .result(result), .dest_o(dest_o),
    .bus_error(bus_error), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  dest;
    logic        berr;
    logic        mis;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int unsigned len;
  } req_t;

  resp_t resp_q[$];
  req_t  req_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  // Response monitor: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      checks++;
      if (resp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid got result=%h dest=%0d berr=%b mis=%b required none",
                 result, dest_o, bus_error, misaligned);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        if (result !== e.result || dest_o !== e.dest || bus_error !== e.berr || misaligned !== e.mis) begin
          errors++;
          $display("FAIL resp got result=%h dest=%0d berr=%b mis=%b required result=%h dest=%0d berr=%b mis=%b",
                   result, dest_o, bus_error, misaligned, e.result, e.dest, e.berr, e.mis);
        end
      end
    end
  end

  // Request monitor: checks bus fields on every request cycle and request length.
  bit          in_req = 1'b0;
  int unsigned req_cycles = 0;
  req_t        cur;
  always @(negedge clk) begin
    if (!reset) begin
      in_req = 1'b0;
    end else if (dmem_req) begin
      if (!in_req) begin
        in_req = 1'b1;
        req_cycles = 0;
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req got addr=%h we=%b be=%b required none", dmem_addr, dmem_we, dmem_be);
          cur = '{addr: dmem_addr, we: dmem_we, be: dmem_be, wdata: dmem_wdata, len: 0};
        end else begin
          cur = req_q.pop_front();
        end
      end
      req_cycles++;
      checks++;
      if (dmem_addr !== cur.addr || dmem_we !== cur.we || dmem_be !== cur.be || dmem_wdata !== cur.wdata) begin
        errors++;
        $display("FAIL req_fields got addr=%h we=%b be=%b wdata=%h required addr=%h we=%b be=%b wdata=%h",
                 dmem_addr, dmem_we, dmem_be, dmem_wdata, cur.addr, cur.we, cur.be, cur.wdata);
      end
    end else if (in_req) begin
      in_req = 1'b0;
      checks++;
      if (req_cycles != cur.len) begin
        errors++;
        $display("FAIL req_len got %0d cycles required %0d", req_cycles, cur.len);
      end
    end
  end

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL %s_idle_timeout got in_ready=%b required 1", tag, in_ready);
    end
  endtask

  // Reference model computes the expected bus request and response from access
  // size and byte offset, then drives the op and plays the memory side.
  task automatic do_op(input bit ld, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] sd, input bit [4:0] d,
                       input int unsigned ack_dly, input bit [31:0] rd);
    int unsigned size, off;
    bit ill, mis, sgn;
    logic [31:0] mask, v;
    resp_t r;
    req_t q;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill  = ld ? (f3 == 3'd3 || f3 >= 3'd6) : (f3 > 3'd2);
    mis  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis  = !ill && ((a % size) != 0);
`endif
    off  = (a % 4) - ((a % 4) % size);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    sgn  = (f3[2] == 1'b0) && (size < 4);

    if (ill || mis) begin
      r = '{result: '0, dest: '0, berr: ill, mis: mis};
    end else begin
      q.addr  = a & 32'hFFFF_FFFC;
      q.we    = !ld;
      q.be    = 4'(((1 << size) - 1) << off);
      q.wdata = ld ? 32'd0 : (sd & mask) * ((size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'd1);
      q.len   = (ack_dly < TMO) ? ack_dly + 1 : TMO;
      req_q.push_back(q);
      if (ack_dly >= TMO) begin
        r = '{result: '0, dest: '0, berr: 1'b1, mis: 1'b0};
      end else if (!ld) begin
        r = '{result: '0, dest: '0, berr: 1'b0, mis: 1'b0};
      end else begin
        v = (rd >> (8 * off)) & mask;
        if (sgn && v[8*size-1]) v = v | ~mask;
        r = '{result: v, dest: d, berr: 1'b0, mis: 1'b0};
      end
    end
    resp_q.push_back(r);

    wait_idle("pre_op");
    in_valid = 1'b1; is_load = ld; is_store = !ld;
    func3 = f3; addr = a; store_data = sd; dest_i = d;
    @(negedge clk);
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; addr = $urandom;
    if (!ill && !mis && ack_dly < TMO) begin
      repeat (ack_dly) @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = rd;
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = $urandom;
    end
    wait_idle("post_op");
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || out_valid !== 1'b0 ||
        bus_error !== 1'b0 || misaligned !== 1'b0 || result !== '0 || dest_o !== '0 ||
        dmem_addr !== '0 || dmem_wdata !== '0 || dmem_be !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b req=%b we=%b ov=%b be=%b addr=%h wd=%h res=%h dest=%0d required rdy=1 and all others 0",
               in_ready, dmem_req, dmem_we, out_valid, dmem_be, dmem_addr, dmem_wdata, result, dest_o);
    end
    reset = 1'b1;
    @(negedge clk);

    do_op(1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd7, 2, 32'h0);
    do_op(1'b1, 3'b000, 32'h203, 32'h0, 5'd5, 0, 32'h8011_2233);
    do_op(1'b1, 3'b100, 32'h203, 32'h0, 5'd5, 1, 32'h8011_2233);
    do_op(1'b0, 3'b001, 32'h302, 32'h0000_ABCD, 5'd0, 0, 32'h0);
    do_op(1'b1, 3'b010, 32'h404, 32'h0, 5'd9, TMO, 32'h0);
    do_op(1'b1, 3'b010, 32'h408, 32'h0, 5'd10, TMO - 1, 32'h1234_5678);
    do_op(1'b1, 3'b010, 32'h401, 32'h0, 5'd11, 0, 32'hCAFE_F00D);
    do_op(1'b1, 3'b101, 32'h503, 32'h0, 5'd12, 0, 32'h9ABC_DEF0);
    do_op(1'b1, 3'b011, 32'h600, 32'h0, 5'd13, 0, 32'h0);
    do_op(1'b0, 3'b100, 32'h604, 32'h55, 5'd0, 0, 32'h0);

    // An op with neither load nor store set, plus a stray ack, must be ignored.
    in_valid = 1'b1; func3 = 3'b010;
    @(negedge clk);
    in_valid = 1'b0; dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL ignore_nop got in_ready=%b dmem_req=%b required 1 0", in_ready, dmem_req);
    end

    for (int i = 0; i < 60; i++) begin
      bit ld;
      bit [2:0] f3;
      int unsigned dly;
      ld  = $urandom_range(1, 0) == 1;
      f3  = ($urandom_range(9, 0) == 0) ? 3'($urandom) :
            ld ? (($urandom_range(4, 0) < 3) ? 3'($urandom_range(2, 0)) : 3'($urandom_range(5, 4)))
               : 3'($urandom_range(2, 0));
      dly = ($urandom_range(11, 0) == 0) ? TMO + 3 : $urandom_range(3, 0);
      do_op(ld, f3, $urandom, $urandom, 5'($urandom), dly, $urandom);
    end

    // Reset in the middle of a request abandons it; a late ack is ignored.
    wait_idle("pre_rst");
    req_q.push_back('{addr: 32'h700, we: 1'b0, be: 4'b1111, wdata: '0, len: 0});
    in_valid = 1'b1; is_load = 1'b1; func3 = 3'b010; addr = 32'h700; dest_i = 5'd3;
    @(negedge clk);
    in_valid = 1'b0; is_load = 1'b0;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_req got dmem_req=%b required 1", dmem_req);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_req got req=%b ov=%b rdy=%b required 0 0 1", dmem_req, out_valid, in_ready);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_ack got rdy=%b req=%b required 1 0", in_ready, dmem_req);
    end

    checks++;
    if (resp_q.size() != 0 || req_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect got resp=%0d req=%0d required 0 0", resp_q.size(), req_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1);
  end

endmodule
